// File: rtl/id_operand_stage.sv
// Decode-operand stage: resolves two source operands (regfile / youngest forward / immediate) into a registered EX bundle.
// Latency: 1 cycle from accept to out_valid. Backpressure: holds output while !out_ready, stalls input on load-use hazard or flush.
// Optional: define ID_STALL_CNT_EN to add the saturating 32-bit stall_cnt output.
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int OP_W    = 8,
  parameter int SEL_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_rs_read,
  input  logic                        in_rt_read,
  input  logic [ADDR_W-1:0]           in_rs_addr,
  input  logic [ADDR_W-1:0]           in_rt_addr,
  input  logic [DATA_W-1:0]           in_imm,
  input  logic [ADDR_W-1:0]           in_wd,
  input  logic                        in_wreg,
  input  logic [OP_W-1:0]             in_aluop,
  input  logic [SEL_W-1:0]            in_alusel,
  input  logic [DATA_W-1:0]           rf_data1,
  input  logic [DATA_W-1:0]           rf_data2,
  input  logic [NUM_FWD-1:0]          fwd_wreg,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]          fwd_pending,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_reg1,
  output logic [DATA_W-1:0]           out_reg2,
  output logic [ADDR_W-1:0]           out_wd,
  output logic                        out_wreg,
  output logic [OP_W-1:0]             out_aluop,
  output logic [SEL_W-1:0]            out_alusel,
  output logic                        stall_o
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [OP_W-1:0]   aluop;
    logic [SEL_W-1:0]  alusel;
  } op_pkt_t;

  state_t  state_q, state_d;
  op_pkt_t pkt_q, pkt_d;

  logic [DATA_W-1:0] opnd1, opnd2;
  logic              hazard1, hazard2;
  logic              accept;

  // Returns {hazard, data}. Scanning from oldest to youngest lets the lowest index win.
  function automatic logic [DATA_W:0] resolve(
    input logic                      rd,
    input logic [ADDR_W-1:0]         addr,
    input logic [DATA_W-1:0]         imm,
    input logic [DATA_W-1:0]         rf,
    input logic [NUM_FWD-1:0]        f_wreg,
    input logic [NUM_FWD*ADDR_W-1:0] f_wd,
    input logic [NUM_FWD*DATA_W-1:0] f_wdata,
    input logic [NUM_FWD-1:0]        f_pend
  );
    logic [DATA_W-1:0] d;
    logic              hz;
    d  = imm;
    hz = 1'b0;
    if (rd) begin
      d = rf;
      if (addr == '0) begin
        d = '0;
      end else begin
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
          if (f_wreg[i] && (f_wd[i*ADDR_W +: ADDR_W] == addr)) begin
            d  = f_wdata[i*DATA_W +: DATA_W];
            hz = f_pend[i];
          end
        end
      end
    end
    return {hz, d};
  endfunction

  always_comb begin
    {hazard1, opnd1} = resolve(in_rs_read, in_rs_addr, in_imm, rf_data1,
                               fwd_wreg, fwd_wd, fwd_wdata, fwd_pending);
    {hazard2, opnd2} = resolve(in_rt_read, in_rt_addr, in_imm, rf_data2,
                               fwd_wreg, fwd_wd, fwd_wdata, fwd_pending);
  end

  assign stall_o   = in_valid && (hazard1 || hazard2);
  assign out_valid = (state_q == FULL);
  assign in_ready  = !flush && !stall_o && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Flush wins over everything; a FULL stage only drains when EX takes it and nothing refills it.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = FULL;
        FULL:    if (out_ready && !accept) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    pkt_d        = pkt_q;
    pkt_d.reg1   = opnd1;
    pkt_d.reg2   = opnd2;
    pkt_d.wd     = in_wd;
    pkt_d.wreg   = in_wreg;
    pkt_d.aluop  = in_aluop;
    pkt_d.alusel = in_alusel;
  end

  always_ff @(posedge clk) begin
    if (rst)         pkt_q <= '0;
    else if (accept) pkt_q <= pkt_d;
  end

  assign out_reg1   = pkt_q.reg1;
  assign out_reg2   = pkt_q.reg2;
  assign out_wd     = pkt_q.wd;
  assign out_wreg   = pkt_q.wreg;
  assign out_aluop  = pkt_q.aluop;
  assign out_alusel = pkt_q.alusel;

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                              stall_cnt <= '0;
    else if (stall_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios then random traffic, all checked cycle by cycle against a behavioural model.
module tb_id_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 2;
  localparam int OW = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic            in_rs_read, in_rt_read;
  logic [AW-1:0]   in_rs_addr, in_rt_addr, in_wd;
  logic [DW-1:0]   in_imm, rf_data1, rf_data2;
  logic            in_wreg;
  logic [OW-1:0]   in_aluop;
  logic [SW-1:0]   in_alusel;
  logic [NF-1:0]   fwd_wreg, fwd_pending;
  logic [NF*AW-1:0] fwd_wd;
  logic [NF*DW-1:0] fwd_wdata;
  logic            flush;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_reg1, out_reg2;
  logic [AW-1:0]   out_wd;
  logic            out_wreg;
  logic [OW-1:0]   out_aluop;
  logic [SW-1:0]   out_alusel;
  logic            stall_o;
`ifdef ID_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  id_operand_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .OP_W(OW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_read(in_rs_read), .in_rt_read(in_rt_read),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_imm(in_imm),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_aluop(in_aluop), .in_alusel(in_alusel),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_reg1(out_reg1), .out_reg2(out_reg2), .out_wd(out_wd), .out_wreg(out_wreg),
    .out_aluop(out_aluop), .out_alusel(out_alusel), .stall_o(stall_o)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Behavioural model of the output register and stall counter.
  logic          m_valid;
  logic [DW-1:0] m_reg1, m_reg2;
  logic [AW-1:0] m_wd;
  logic          m_wreg;
  logic [OW-1:0] m_aluop;
  logic [SW-1:0] m_alusel;
  longint        m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Spec rule: immediate, r0 reads zero, first matching forward source (lowest index), else regfile.
  function automatic void pick(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] rf,
                               output logic [DW-1:0] v, output logic hz);
    bit found = 0;
    hz = 1'b0;
    if (!rd) v = in_imm;
    else if (a == 0) v = '0;
    else begin
      v = rf;
      for (int i = 0; i < NF; i++) begin
        if (!found && fwd_wreg[i] && fwd_wd[i*AW +: AW] == a) begin
          found = 1;
          hz    = fwd_pending[i];
          v     = fwd_wdata[i*DW +: DW];
        end
      end
    end
  endfunction

  // One clock: check combinational outputs, clock, advance model, check registered outputs.
  task automatic cycle(input string tag);
    logic [DW-1:0] o1, o2;
    logic hz1, hz2, e_stall, e_ready, acc;
    #1;
    pick(in_rs_read, in_rs_addr, rf_data1, o1, hz1);
    pick(in_rt_read, in_rt_addr, rf_data2, o2, hz2);
    e_stall = in_valid && (hz1 || hz2);
    e_ready = !flush && !e_stall && (!m_valid || out_ready);
    acc     = in_valid && e_ready;
    chk({tag, ".stall_o"}, stall_o, e_stall);
    chk({tag, ".in_ready"}, in_ready, e_ready);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_reg1 = 0; m_reg2 = 0; m_wd = 0; m_wreg = 0; m_aluop = 0; m_alusel = 0; m_cnt = 0;
    end else begin
      if (e_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_reg1 = o1; m_reg2 = o2; m_wd = in_wd; m_wreg = in_wreg;
        m_aluop = in_aluop; m_alusel = in_alusel;
      end else if (out_ready) m_valid = 0;
    end
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".out_reg1"}, out_reg1, m_reg1);
    chk({tag, ".out_reg2"}, out_reg2, m_reg2);
    chk({tag, ".out_wd"}, out_wd, m_wd);
    chk({tag, ".out_wreg"}, out_wreg, m_wreg);
    chk({tag, ".out_aluop"}, out_aluop, m_aluop);
    chk({tag, ".out_alusel"}, out_alusel, m_alusel);
`ifdef ID_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_cnt[31:0]);
`endif
  endtask

  initial begin
`ifdef ID_STALL_CNT_EN
    logic [31:0] cnt0;
`endif
    m_valid = 0; m_reg1 = 0; m_reg2 = 0; m_wd = 0; m_wreg = 0; m_aluop = 0; m_alusel = 0; m_cnt = 0;
    rst = 1; in_valid = 0; in_rs_read = 0; in_rt_read = 0; in_rs_addr = 0; in_rt_addr = 0;
    in_imm = 0; in_wd = 0; in_wreg = 0; in_aluop = 0; in_alusel = 0; rf_data1 = 0; rf_data2 = 0;
    fwd_wreg = 0; fwd_wd = 0; fwd_wdata = 0; fwd_pending = 0; flush = 0; out_ready = 1;

    cycle("rst0");
    cycle("rst1");
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_reg1", out_reg1, 0);
    rst = 0;

    // 1: plain regfile read
    in_valid = 1; in_rs_read = 1; in_rs_addr = 3; in_rt_read = 0; in_imm = 32'h77;
    rf_data1 = 32'h11; in_wd = 7; in_wreg = 1; in_aluop = 8'h21; in_alusel = 3'd1;
    cycle("t1");
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_reg1", out_reg1, 32'h11);
    chk("t1_reg2_imm", out_reg2, 32'h77);

    // 2: youngest forward wins; then the older one
    fwd_wreg = 2'b11; fwd_wd = {5'd3, 5'd3}; fwd_wdata = {32'hBB, 32'hAA};
    cycle("t2a");
    chk("t2_young", out_reg1, 32'hAA);
    fwd_wreg = 2'b10;
    cycle("t2b");
    chk("t2_old", out_reg1, 32'hBB);

    // 3: load-use stall for two cycles, output drains meanwhile
`ifdef ID_STALL_CNT_EN
    cnt0 = stall_cnt;
`endif
    in_rs_addr = 4; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd4}; fwd_wdata = {32'h0, 32'hCC};
    fwd_pending = 2'b01;
    #1 chk("t3_stall", stall_o, 1'b1);
    chk("t3_noready", in_ready, 1'b0);
    cycle("t3s1");
    chk("t3_drained", out_valid, 1'b0);
    cycle("t3s2");
    fwd_pending = 2'b00;
    cycle("t3go");
    chk("t3_fwd", out_reg1, 32'hCC);
`ifdef ID_STALL_CNT_EN
    chk("t3_cnt", stall_cnt - cnt0, 32'd2);
`endif

    // 4: backpressure hold then back-to-back
    fwd_wreg = 0; out_ready = 0; rf_data1 = 32'h99; in_rs_addr = 6;
    for (int k = 0; k < 3; k++) begin
      cycle("t4hold");
      chk("t4_stable", out_reg1, 32'hCC);
    end
    out_ready = 1;
    cycle("t4b2b");
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_new", out_reg1, 32'h99);

    // 5: r0 never forwarded; immediate path
    in_rs_addr = 0; fwd_wreg = 2'b01; fwd_wd = 0; fwd_wdata = {32'h0, 32'h55};
    cycle("t5r0");
    chk("t5_r0", out_reg1, 32'h0);
    in_rs_read = 0; in_imm = 32'h1234;
    cycle("t5imm");
    chk("t5_imm", out_reg1, 32'h1234);

    // 6: flush while FULL, then reset mid-stream
    flush = 1; in_imm = 32'h4321;
    cycle("t6fl");
    chk("t6_flush_valid", out_valid, 1'b0);
    chk("t6_flush_hold", out_reg1, 32'h1234);
    flush = 0;
    cycle("t6re");
    rst = 1;
    cycle("t6rst");
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_reg1", out_reg1, 0);
    chk("t6_rst_aluop", out_aluop, 0);
    rst = 0;

    // Random traffic, small address space to provoke forwarding and hazards
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_valid    = ($urandom_range(0, 4) != 0);
      in_rs_read  = $urandom_range(0, 1);
      in_rt_read  = $urandom_range(0, 1);
      in_rs_addr  = AW'($urandom_range(0, 3));
      in_rt_addr  = AW'($urandom_range(0, 3));
      in_imm      = $urandom;
      rf_data1    = $urandom;
      rf_data2    = $urandom;
      in_wd       = AW'($urandom);
      in_wreg     = $urandom_range(0, 1);
      in_aluop    = OW'($urandom);
      in_alusel   = SW'($urandom);
      fwd_wreg    = NF'($urandom);
      fwd_wd      = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      fwd_wdata   = {$urandom, $urandom};
      fwd_pending = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
